// File: rtl/br_delay_skew.sv
// Transmit side of a valid-early link: out_valid_next is in_valid passed straight through,
// and the beat itself reaches out LeadCycles cycles later through a valid-gated pipeline.
module br_delay_skew #(
  parameter int Width                     = 1,
  parameter int LeadCycles                = 1,
  parameter bit EnableAssertFinalNotValid = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [Width-1:0] in,
  output logic             out_valid_next,
  output logic             out_valid,
  output logic [Width-1:0] out
);

  logic [LeadCycles:1]            v;
  logic [LeadCycles:1][Width-1:0] d;

  assign out_valid_next = in_valid;
  assign out_valid      = v[LeadCycles];
  assign out            = d[LeadCycles];

  // Data stages only move on a valid beat, so out holds steady across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      d <= '0;
    end else begin
      v[1] <= in_valid;
      if (in_valid) d[1] <= in;
      for (int i = 2; i <= LeadCycles; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

`ifndef SYNTHESIS
  if (Width < 1 || LeadCycles < 1) begin : g_bad_params
    $error("br_delay_skew: Width and LeadCycles must both be >= 1");
  end

  localparam int CntW = $clog2(LeadCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(LeadCycles);

  // Cycles since reset release, saturating; $past history is only trustworthy after LeadCycles.
  logic [CntW-1:0] since_rst;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  since_rst <= '0;
    else if (since_rst != CntMax) since_rst <= since_rst + 1'b1;
  end

  a_in_valid_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(in_valid));
  c_in_valid: cover property (@(posedge clk) disable iff (!rst_n) in_valid);
  a_valid_delay: assert property (@(posedge clk) disable iff (!rst_n)
    (since_rst == CntMax) |-> (out_valid == $past(in_valid, LeadCycles)));
  a_data_delay: assert property (@(posedge clk) disable iff (!rst_n)
    (since_rst == CntMax && out_valid) |-> (out == $past(in, LeadCycles)));
  a_next_passthru: assert property (@(posedge clk) out_valid_next === in_valid);

  final begin
    if (EnableAssertFinalNotValid) begin
      a_final_not_valid: assert (!in_valid && !out_valid_next && !out_valid);
    end
  end
`endif

endmodule

// File: tb/tb_br_delay_skew.sv
// Directed table plus hand-written sequences for br_delay_skew at LeadCycles=1 and 3,
// then random traffic checked against a delay-line model and a deskew-receiver model.
module tb_br_delay_skew;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic       vn1, ov1, vn3, ov3;
  logic [7:0] o1, o3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  br_delay_skew #(.Width(8), .LeadCycles(1), .EnableAssertFinalNotValid(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
    .out_valid_next(vn1), .out_valid(ov1), .out(o1));

  br_delay_skew #(.Width(8), .LeadCycles(3), .EnableAssertFinalNotValid(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
    .out_valid_next(vn3), .out_valid(ov3), .out(o3));

  // Valid-early deskew receiver with LeadCycles=1: register the early valid, take data as it lands.
  logic rx_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_v <= 1'b0;
    else        rx_v <= vn1;
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       vn;
    logic       ov1;
    logic [7:0] o1;
    logic       ov3;
    logic [7:0] o3;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in       = d;
    #1;
  endtask

  // Model state for random phase: pv/pd[k] = input k steps ago.
  logic       pv[4];
  logic [7:0] pd[4];
  logic [7:0] e1, e3;

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 8'hA5};
    tbl[4]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5};
    tbl[5]  = '{1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 8'hA5};
    tbl[6]  = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h02, 1'b0, 8'hA5};
    tbl[7]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h03, 1'b1, 8'h01};
    tbl[8]  = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h03, 1'b1, 8'h02};
    tbl[9]  = '{1'b0, 8'h55, 1'b0, 1'b1, 8'h11, 1'b1, 8'h03};
    tbl[10] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h11, 1'b0, 8'h03};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 8'h11};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 8'h11};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 8'h22};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 8'h22};

    // Reset state
    #12;
    chk("rst_ov1", ov1, 1'b0);
    chk("rst_o1",  o1,  8'h00);
    chk("rst_ov3", ov3, 1'b0);
    chk("rst_o3",  o3,  8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].v, tbl[k].d);
      chk($sformatf("tbl%0d_vn1", k), vn1, tbl[k].vn);
      chk($sformatf("tbl%0d_vn3", k), vn3, tbl[k].vn);
      chk($sformatf("tbl%0d_ov1", k), ov1, tbl[k].ov1);
      chk($sformatf("tbl%0d_o1",  k), o1,  tbl[k].o1);
      chk($sformatf("tbl%0d_ov3", k), ov3, tbl[k].ov3);
      chk($sformatf("tbl%0d_o3",  k), o3,  tbl[k].o3);
    end

    // Reset mid-flight: two beats in the LeadCycles=3 pipe, then async reset mid-cycle
    drive(1'b1, 8'h77);
    drive(1'b1, 8'h88);
    drive(1'b0, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov3", ov3, 1'b0);
    chk("mid_rst_o3",  o3,  8'h00);
    chk("mid_rst_ov1", ov1, 1'b0);
    chk("mid_rst_o1",  o1,  8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 8'h00);
      chk($sformatf("post_rst%0d_ov3", k), ov3, 1'b0);
      chk($sformatf("post_rst%0d_o3",  k), o3,  8'h00);
      chk($sformatf("post_rst%0d_ov1", k), ov1, 1'b0);
    end

    // Random traffic against delay-line model and receiver composition
    for (int j = 0; j < 4; j++) begin pv[j] = 1'b0; pd[j] = 8'h00; end
    e1 = 8'h00;
    e3 = 8'h00;
    for (int k = 0; k < 1000; k++) begin
      logic       rv;
      logic [7:0] rd;
      rv = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      for (int j = 3; j > 0; j--) begin pv[j] = pv[j-1]; pd[j] = pd[j-1]; end
      pv[0] = rv;
      pd[0] = rd;
      if (pv[1]) e1 = pd[1];
      if (pv[3]) e3 = pd[3];
      drive(rv, rd);
      chk("rnd_vn1", vn1, rv);
      chk("rnd_ov1", ov1, pv[1]);
      chk("rnd_o1",  o1,  e1);
      chk("rnd_ov3", ov3, pv[3]);
      chk("rnd_o3",  o3,  e3);
      chk("rx_valid", rx_v, pv[1]);
      if (rx_v) chk("rx_data", o1, pd[1]);
    end

    // Drain so every valid is low at end of test
    for (int k = 0; k < 4; k++) drive(1'b0, 8'h00);
    chk("drain_ov1", ov1, 1'b0);
    chk("drain_ov3", ov3, 1'b0);
    chk("drain_vn1", vn1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
